// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner of the 4-digit BCD display with a minimum hold slice.
// Optional idle blanking is compiled in with SEG_ARB_BLANK_EN.
`default_nettype none

module seg_disp_arbiter #(
  parameter int HOLD_CYCLES = 200_000_000,
  parameter int TMR_W       = 28
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        blank
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] EXPIRY = TMR_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rr_q, rr_d;          // 1: B is next in line on a tie
  logic [15:0]      digits_q, digits_d;
  logic             gnt_a_q, gnt_b_q;
  logic             expired;

  function automatic logic [15:0] sanitise(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'h0;
    end
    return r;
  endfunction

  assign expired = (timer_q == EXPIRY);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_d     = rr_q;
    digits_d = digits_q;

    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !rr_q)) state_d = SHOW_A;
        else if (req_b)                 state_d = SHOW_B;
      end
      SHOW_A: begin
        // The other side only gets in on early release or slice expiry.
        if (!req_a || expired) begin
          if (req_b)       state_d = SHOW_B;
          else if (!req_a) state_d = IDLE;
        end
      end
      SHOW_B: begin
        if (!req_b || expired) begin
          if (req_a)       state_d = SHOW_A;
          else if (!req_b) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)     timer_d = '0;
    else if (state_q != IDLE)   timer_d = expired ? '0 : timer_q + 1'b1;

    if (state_d != state_q && state_d != IDLE) rr_d = (state_d == SHOW_A);

    if (state_d == SHOW_A)      digits_d = sanitise(data_a);
    else if (state_d == SHOW_B) digits_d = sanitise(data_b);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      rr_q     <= 1'b0;
      digits_q <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_q     <= rr_d;
      digits_q <= digits_d;
      gnt_a_q  <= (state_d == SHOW_A);
      gnt_b_q  <= (state_d == SHOW_B);
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign thousands = digits_q[15:12];
  assign hundreds  = digits_q[11:8];
  assign tens      = digits_q[7:4];
  assign ones      = digits_q[3:0];

`ifdef SEG_ARB_BLANK_EN
  logic [TMR_W-1:0] idle_q, idle_d;
  logic             blank_q, blank_d;

  // Idle counter saturates once the blank threshold is reached.
  always_comb begin
    idle_d  = '0;
    blank_d = 1'b0;
    if (state_q == IDLE && state_d == IDLE) begin
      blank_d = blank_q;
      if (idle_q == EXPIRY) begin
        idle_d  = idle_q;
        blank_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      idle_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

endmodule

`default_nettype wire
